// File: rtl/matrix_readout_pkg.sv
`default_nettype none
// ============================================================================
// Package : matrix_readout_pkg
// Purpose : shared widths, word layout and FSM encoding for the matrix reader
// Revision: 1.0
// ============================================================================
package matrix_readout_pkg;

  localparam int COL_ADDR_W = 6;
  localparam int COL_DATA_W = 21;
  localparam int BCID_W     = 6;
  localparam int WORD_W     = 33;

  // Field order fixes the output word layout {addr, bcid, data}.
  typedef struct packed {
    logic [COL_ADDR_W-1:0] addr;
    logic [BCID_W-1:0]     bcid;
    logic [COL_DATA_W-1:0] data;
  } readout_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_HI = 2'd1,
    RD_LO = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/readout_fifo.sv
`default_nettype none
// ============================================================================
// Module  : readout_fifo
// Purpose : synchronous word FIFO, registered head, no fall-through
// Revision: 1.0
// ============================================================================
module readout_fifo
  import matrix_readout_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] din,
  input  logic              pop,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int                c_addr_w  = $clog2(FIFO_DEPTH);
  localparam logic [c_addr_w:0] c_ptr_one = 1;

  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_addr_w:0] r_wr_ptr;
  logic [c_addr_w:0] r_rd_ptr;
  logic              w_push;
  logic              w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= din;
    end
  end

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                 (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
  assign dout  = r_mem[r_rd_ptr[c_addr_w-1:0]];

endmodule
`default_nettype wire

// File: rtl/matrix_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : matrix_readout_ctrl
// Purpose : token-ring READ sequencer capturing column words into a FIFO
// Revision: 1.0
// ============================================================================
module matrix_readout_ctrl
  import matrix_readout_pkg::*;
#(
  parameter int READ_HIGH  = 2,
  parameter int READ_LOW   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  token_in,
  output logic                  read,
  input  logic [COL_ADDR_W-1:0] col_addr_in,
  input  logic [COL_DATA_W-1:0] col_data_in,
  input  logic [BCID_W-1:0]     bcid_in,
  output logic [WORD_W-1:0]     data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic [15:0]           hit_cnt,
  output logic                  fifo_full
);

  localparam logic [3:0] c_hi_load = 4'(READ_HIGH - 1);
  localparam logic [3:0] c_lo_load = 4'(READ_LOW - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_tok_meta;
  logic          r_tok_s;
  logic [3:0]    r_cnt;
  logic          r_read;
  logic [15:0]   r_hit_cnt;
  logic          w_read_d;
  logic          w_capture;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  readout_word_t w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tok_meta <= 1'b0;
      r_tok_s    <= 1'b0;
    end else begin
      r_tok_meta <= token_in;
      r_tok_s    <= r_tok_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Fullness is only consulted here, so a started read always has a slot.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (en && r_tok_s && !w_fifo_full) w_state_next = RD_HI;
      RD_HI:   if (r_cnt == 4'd0) w_state_next = RD_LO;
      RD_LO:   if (r_cnt == 4'd0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_read_d  = (w_state_next == RD_HI);
    w_capture = (r_state == RD_HI) && (r_cnt == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read    <= 1'b0;
      r_cnt     <= 4'd0;
      r_hit_cnt <= 16'd0;
    end else begin
      r_read <= w_read_d;
      if (r_state == IDLE && w_state_next == RD_HI) begin
        r_cnt <= c_hi_load;
      end else if (r_state == RD_HI && w_state_next == RD_LO) begin
        r_cnt <= c_lo_load;
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) r_hit_cnt <= r_hit_cnt + 16'd1;
    end
  end

  always_comb begin
    w_word      = '0;
    w_word.addr = col_addr_in;
    w_word.bcid = bcid_in;
    w_word.data = col_data_in;
  end

  assign w_pop = valid_out & ready_in;

  readout_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (w_capture),
    .din  (w_word),
    .pop  (w_pop),
    .dout (data_out),
    .full (w_fifo_full),
    .empty(w_fifo_empty)
  );

  assign read      = r_read;
  assign busy      = (r_state != IDLE);
  assign valid_out = ~w_fifo_empty;
  assign hit_cnt   = r_hit_cnt;
  assign fifo_full = w_fifo_full;

endmodule
`default_nettype wire
